// File: rtl/sm83_pkg.sv
// Shared SM83 front-end types: fetch states, opcode byte type, reset PC and
// the fetch buffer entry layout.
package sm83_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  typedef logic [7:0] instr_t;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam instr_t      OP_INSTR_16 = 8'hCB;

  localparam int unsigned FETCH_ENTRY_W = 24;

  typedef struct packed {
    instr_t      instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small in-order byte buffer between memory fetch and decode; head entry is
// always slot 0, popping shifts the remaining entries down.
module fetch_buf
  import sm83_pkg::*;
#(
  parameter  int unsigned DEPTH = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FETCH_ENTRY_W-1:0] wdata,
  output logic [FETCH_ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]         count,
  output logic                     empty
);

  logic [FETCH_ENTRY_W-1:0] mem [DEPTH];
  logic                     do_pop;
  logic [CNT_W-1:0]         wr_idx;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign wr_idx = count - CNT_W'(do_pop);
  assign head   = mem[0];

  // Push lands behind whatever survives this cycle's pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CNT_W'(i) == wr_idx) mem[i] <= wdata;
        end
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch.sv
// SM83 instruction byte fetch with CB-prefix tracking, redirect and halt.
// Define FETCH_PREFETCH_EN for a 2-entry buffer (1 byte/cycle), else 1 entry.
module fetch
  import sm83_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic [7:0]  o_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_is_instr16,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  input  logic        i_wake
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned BUF_DEPTH = 2;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     state, state_nxt;
  logic [15:0]      fetch_pc, fetch_pc_nxt;
  logic [15:0]      target_pc, target_pc_nxt;
  logic             req, req_nxt;
  logic             prefix, prefix_nxt;
  logic             buf_push, buf_pop, buf_flush, buf_empty;
  logic [CNT_W-1:0] buf_count, cnt_nxt;
  fetch_entry_t     wr_entry, head_entry;
  logic             accept, acked, pending;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (buf_flush),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (wr_entry),
    .head  (head_entry),
    .count (buf_count),
    .empty (buf_empty)
  );

  assign wr_entry     = '{instr: i_mem_rdata, pc: fetch_pc};
  assign o_valid      = !buf_empty;
  assign o_instr      = head_entry.instr;
  assign o_pc         = head_entry.pc;
  assign o_mem_req    = req;
  assign o_mem_addr   = fetch_pc;
  assign o_is_instr16 = prefix;

  assign accept  = o_valid && i_ready;
  assign acked   = req && i_mem_ack;
  assign pending = req && !i_mem_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      req       <= 1'b0;
      prefix    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      target_pc <= target_pc_nxt;
      req       <= req_nxt;
      prefix    <= prefix_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    target_pc_nxt = target_pc;
    req_nxt       = req;
    prefix_nxt    = prefix;
    buf_push      = 1'b0;
    buf_pop       = accept;
    buf_flush     = 1'b0;

    if (accept) prefix_nxt = !prefix && (o_instr == OP_INSTR_16);
    if (acked) req_nxt = 1'b0;

    // Redirect wins over everything; an in-flight read must drain first.
    if (i_redirect) begin
      buf_flush     = 1'b1;
      prefix_nxt    = 1'b0;
      target_pc_nxt = i_redirect_pc;
      if (pending) begin
        state_nxt = ST_DRAIN;
      end else begin
        state_nxt    = ST_RUN;
        fetch_pc_nxt = i_redirect_pc;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (i_halt) begin
            // Buffered bytes are consecutive, so resume at the oldest unaccepted one.
            buf_flush     = 1'b1;
            state_nxt     = ST_HALTED;
            target_pc_nxt = fetch_pc - 16'(buf_count - CNT_W'(accept));
          end else if (acked) begin
            buf_push     = 1'b1;
            fetch_pc_nxt = fetch_pc + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (i_halt) begin
            state_nxt = ST_HALTED;
          end else if (acked) begin
            state_nxt    = ST_RUN;
            fetch_pc_nxt = target_pc;
          end
        end
        ST_HALTED: begin
          if (i_wake) begin
            if (pending) begin
              state_nxt = ST_DRAIN;
            end else begin
              state_nxt    = ST_RUN;
              fetch_pc_nxt = target_pc;
            end
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end

    // Issue a new read whenever RUN has a free slot after this cycle's traffic.
    cnt_nxt = buf_flush ? '0 : buf_count + CNT_W'(buf_push) - CNT_W'(buf_pop && !buf_empty);
    if (state_nxt == ST_RUN && !pending) req_nxt = (cnt_nxt < CNT_W'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: byte-stream / request-address reference model
// plus directed scenarios with literal expectations.
module tb_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [7:0]  i_mem_rdata;
  logic [7:0]  o_instr;
  logic        o_valid;
  logic        i_ready;
  logic        o_is_instr16;
  logic [15:0] o_pc;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt;
  logic        i_wake;

  fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_instr(o_instr), .o_valid(o_valid),
    .i_ready(i_ready), .o_is_instr16(o_is_instr16), .o_pc(o_pc), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_halt(i_halt), .i_wake(i_wake)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] mem [65536];
  int n_pass = 0, n_total = 0;

  // reference model state
  logic [15:0] exp_pc, exp_fetch;
  logic        exp_pfx, discard_pending, halted;
  int          occ;

  // responder / history
  int          lat_left = 0;
  logic        prev_req = 0, prev_ack = 0, prev_valid = 0, prev_ready = 0, prev_flush = 0;
  logic [15:0] prev_addr = 0, prev_pc = 0;
  logic [7:0]  prev_instr = 0;

  // stimulus plan
  int          ready_mode = 1, lat_fix = -1;
  logic        plan_redirect = 0, plan_need_pending = 0, plan_halt = 0, plan_wake = 0;
  logic [15:0] plan_rpc = 0;

  // recorded traffic for literal checks
  logic [15:0] reqq[$], acc_pc[$];
  logic [7:0]  acc_ins[$];
  logic        acc_pfx[$];
  int          rmark = 0, amark = 0, hmark = 0, wmark = 0, wamark = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    logic nr, ack, accept, redir, hlt, wk;
    @(negedge i_clk);
    nr = o_mem_req && (!prev_req || prev_ack);
    if (nr) begin
      lat_left = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      reqq.push_back(o_mem_addr);
    end
    ack = o_mem_req && (lat_left == 0);
    if (o_mem_req && lat_left > 0) lat_left--;
    i_mem_ack   = ack;
    i_mem_rdata = ack ? mem[o_mem_addr] : 8'($urandom);
    case (ready_mode)
      0:       i_ready = ($urandom_range(0, 3) != 0);
      1:       i_ready = 1'b1;
      default: i_ready = 1'b0;
    endcase

    chk("valid", 32'(o_valid), 32'(occ != 0));
    if (o_valid) begin
      chk("pc", 32'(o_pc), 32'(exp_pc));
      chk("instr", 32'(o_instr), 32'(mem[exp_pc]));
      chk("is_instr16", 32'(o_is_instr16), 32'(exp_pfx));
    end
    if (prev_req && !prev_ack) begin
      chk("req_hold", 32'(o_mem_req), 32'd1);
      chk("addr_hold", 32'(o_mem_addr), 32'(prev_addr));
    end
    if (prev_valid && !prev_ready && !prev_flush && o_valid) begin
      chk("instr_stable", 32'(o_instr), 32'(prev_instr));
      chk("pc_stable", 32'(o_pc), 32'(prev_pc));
    end
    if (nr) begin
      chk("req_addr", 32'(o_mem_addr), 32'(exp_fetch));
      chk("req_while_halted", 32'(halted), 32'd0);
      chk("req_with_room", 32'(occ < DEPTH), 32'd1);
    end

    redir = plan_redirect && (!plan_need_pending || (o_mem_req && !ack));
    hlt   = plan_halt;
    wk    = plan_wake;
    i_redirect    = redir;
    i_redirect_pc = plan_rpc;
    i_halt        = hlt;
    i_wake        = wk;
    plan_halt = 0;
    plan_wake = 0;
    if (redir) begin
      plan_redirect = 0;
      rmark = reqq.size();
      amark = acc_pc.size();
    end

    accept = o_valid && i_ready;
    if (accept && !redir) begin
      acc_pc.push_back(o_pc);
      acc_ins.push_back(o_instr);
      acc_pfx.push_back(o_is_instr16);
    end

    // model: the stream delivered to decode is consecutive bytes from the last
    // redirect target; halt/wake must not lose or repeat any unaccepted byte
    if (redir) begin
      occ = 0;
      exp_pc = plan_rpc;
      exp_pfx = 0;
      exp_fetch = plan_rpc;
      discard_pending = o_mem_req && !ack;
      halted = 0;
    end else begin
      if (accept) begin
        occ--;
        exp_pfx = !exp_pfx && (mem[exp_pc] == 8'hCB);
        exp_pc = exp_pc + 16'd1;
      end
      if (hlt && !halted) begin
        occ = 0;
        halted = 1;
        discard_pending = o_mem_req && !ack;
        exp_fetch = exp_pc;
        hmark = reqq.size();
      end else begin
        if (ack) begin
          if (discard_pending) discard_pending = 0;
          else begin
            occ++;
            exp_fetch = o_mem_addr + 16'd1;
          end
        end
        if (wk && halted) begin
          halted = 0;
          wmark = reqq.size();
          wamark = acc_pc.size();
        end
      end
    end

    prev_req = o_mem_req;   prev_ack = ack;      prev_addr = o_mem_addr;
    prev_valid = o_valid;   prev_ready = i_ready;
    prev_instr = o_instr;   prev_pc = o_pc;      prev_flush = redir || hlt;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [7:0] exp_ins [4];
    logic       exp_flag [4];
    logic [15:0] wrap_pc [3];
    int s;
    exp_ins  = '{8'hCB, 8'h37, 8'hCB, 8'hCB};
    exp_flag = '{1'b0, 1'b1, 1'b0, 1'b1};
    wrap_pc  = '{16'hFFFE, 16'hFFFF, 16'h0000};

    for (int a = 0; a < 65536; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'hCB; mem[2] = 8'h37; mem[3] = 8'hCB; mem[4] = 8'hCB;

    exp_pc = 16'h0000; exp_fetch = 16'h0000; exp_pfx = 0;
    discard_pending = 0; halted = 0; occ = 0;
    i_rst_n = 0; i_mem_ack = 0; i_mem_rdata = 0; i_ready = 0;
    i_redirect = 0; i_redirect_pc = 0; i_halt = 0; i_wake = 0;

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_is_instr16", 32'(o_is_instr16), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    i_rst_n = 1;

    // first request right after release; prefix stream from 0x0000
    ready_mode = 1; lat_fix = -1;
    step();
    chk("first_req", 32'(o_mem_req), 32'd1);
    run(40);
    chk("stream_len", 32'(acc_pc.size() >= 5), 32'd1);
    if (acc_pc.size() >= 5) begin
      chk("first_pc", 32'(acc_pc[0]), 32'h0000);
      chk("first_instr", 32'(acc_ins[0]), 32'h00);
      for (int i = 0; i < 4; i++) begin
        chk("cb_instr", 32'(acc_ins[i+1]), 32'(exp_ins[i]));
        chk("cb_flag", 32'(acc_pfx[i+1]), 32'(exp_flag[i]));
      end
    end

    // redirect while a slow read is outstanding
    lat_fix = 3; plan_rpc = 16'h0150; plan_redirect = 1; plan_need_pending = 1;
    run(25);
    chk("redir_applied", 32'(plan_redirect), 32'd0);
    chk("redir_req_seen", 32'(reqq.size() > rmark), 32'd1);
    if (reqq.size() > rmark) chk("redir_req_addr", 32'(reqq[rmark]), 32'h0150);
    chk("redir_acc_seen", 32'(acc_pc.size() > amark), 32'd1);
    if (acc_pc.size() > amark) chk("redir_acc_pc", 32'(acc_pc[amark]), 32'h0150);

    // address wrap
    lat_fix = -1; plan_need_pending = 0; plan_rpc = 16'hFFFE; plan_redirect = 1;
    run(30);
    chk("wrap_len", 32'(reqq.size() >= rmark + 3 && acc_pc.size() >= amark + 3), 32'd1);
    if (reqq.size() >= rmark + 3 && acc_pc.size() >= amark + 3)
      for (int i = 0; i < 3; i++) begin
        chk("wrap_req", 32'(reqq[rmark+i]), 32'(wrap_pc[i]));
        chk("wrap_acc", 32'(acc_pc[amark+i]), 32'(wrap_pc[i]));
      end

    // decode stalls: buffer fills, requests stop, head is held
    lat_fix = 0; ready_mode = 2; plan_rpc = 16'h0300; plan_redirect = 1;
    run(8);
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_pc", 32'(o_pc), 32'h0300);
    chk("stall_no_req", 32'(o_mem_req), 32'd0);

    // halt, stay halted 10 cycles, wake and resume at the held byte
    plan_halt = 1;
    step();
    ready_mode = 0;
    run(10);
    plan_wake = 1;
    step();
    chk("halt_no_reqs", 32'(wmark), 32'(hmark));
    ready_mode = 1;
    run(20);
    chk("wake_req_seen", 32'(reqq.size() > wmark), 32'd1);
    if (reqq.size() > wmark) chk("wake_req_addr", 32'(reqq[wmark]), 32'h0300);
    chk("wake_acc_seen", 32'(acc_pc.size() > wamark), 32'd1);
    if (acc_pc.size() > wamark) chk("wake_acc_pc", 32'(acc_pc[wamark]), 32'h0300);

    // throughput with instant acks and a ready decoder
    plan_rpc = 16'h1000; plan_redirect = 1;
    run(10);
    s = acc_pc.size();
    run(20);
    chk("throughput", 32'(acc_pc.size() - s), (DEPTH == 2) ? 32'd20 : 32'd10);

    // randomized traffic
    ready_mode = 0; lat_fix = -1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        plan_redirect = 1;
        plan_rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                               : 16'($urandom);
      end
      if (!halted && $urandom_range(0, 99) == 0) plan_halt = 1;
      if (halted && $urandom_range(0, 9) == 0) plan_wake = 1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
